regfile_sb: RTL and testbench

Parametrised integer register file with a built-in write-pending scoreboard, for the 5-stage RISC-V pipeline. Provides NREAD combinational read ports, one synchronous write port, optional same-cycle write-to-read bypass and per-register pending bits set at issue (ID) and cleared at writeback (WB). The hazard unit consumes per-port busy flags to stall. It replaces the fixed 32x32, two-read-port register file.

---
 rtl/regfile_pkg.sv | 12 +
 rtl/rf_scoreboard.sv | 41 ++++
 rtl/regfile_sb.sv | 51 +++++
 tb/tb_regfile_sb.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and address helpers for the register file slice
package regfile_pkg;
  localparam int XLEN_DEF = 32;
  localparam int REG_ZERO = 0;
  function automatic logic addr_valid(input logic [31:0] addr, input int nregs);
    return addr < 32'(nregs);
  endfunction
  // Valid and not the hardwired zero register: the only addresses that hold state
  function automatic logic addr_live(input logic [31:0] addr, input int nregs, input int zero_reg);
    return addr_valid(addr, nregs) && !(zero_reg != 0 && addr == 32'(REG_ZERO));
  endfunction
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register pending bits with issue > flush > write priority
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int NREAD = 2,
  parameter int ZERO_REG = 1,
  localparam int AW = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_rd,
  input  logic                flush,
  input  logic [NREAD*AW-1:0] rd_addr,
  output logic [NREAD-1:0]    busy,
  output logic                any_busy
);
  logic [NREGS-1:0] pend_q, pend_d;
  logic wr_ok, iss_ok;
  always_comb begin
    wr_ok = wr_en && addr_live(32'(wr_addr), NREGS, ZERO_REG);
    iss_ok = iss_en && addr_live(32'(iss_rd), NREGS, ZERO_REG);
    pend_d = pend_q;
    for (int r = 0; r < NREGS; r++)
      pend_d[r] = (iss_ok && iss_rd == AW'(r)) ? 1'b1 :
                  flush ? 1'b0 :
                  (wr_ok && wr_addr == AW'(r)) ? 1'b0 : pend_q[r];
  end
  always_ff @(posedge clk)
    if (reset) pend_q <= '0;
    else pend_q <= pend_d;
  always_comb begin
    busy = '0;
    for (int p = 0; p < NREAD; p++)
      busy[p] = addr_live(32'(rd_addr[p*AW +: AW]), NREGS, ZERO_REG) ? pend_q[rd_addr[p*AW +: AW]] : 1'b0;
  end
  assign any_busy = |pend_q;
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with write bypass and pending-write scoreboard
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREGS = 32,
  parameter int NREAD = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS = 1,
  localparam int AW = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREAD*AW-1:0]   rd_addr,
  output logic [NREAD*XLEN-1:0] rd_data,
  output logic [NREAD-1:0]      rd_busy,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [XLEN-1:0]       wr_data,
  input  logic                  iss_en,
  input  logic [AW-1:0]         iss_rd,
  input  logic                  flush,
  output logic                  any_busy
);
  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic [NREAD-1:0] busy_raw;
  logic w_ok;
  always_comb begin
    w_ok = wr_en && addr_live(32'(wr_addr), NREGS, ZERO_REG);
    regs_d = regs_q;
    if (w_ok) regs_d[wr_addr] = wr_data;
  end
  always_ff @(posedge clk)
    if (reset) regs_q <= '{default: '0};
    else regs_q <= regs_d;
  rf_scoreboard #(.NREGS(NREGS), .NREAD(NREAD), .ZERO_REG(ZERO_REG)) u_sb (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .iss_en(iss_en),
    .iss_rd(iss_rd), .flush(flush), .rd_addr(rd_addr), .busy(busy_raw), .any_busy(any_busy)
  );
  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [AW-1:0] a;
    logic ok, hit;
    assign a = rd_addr[i*AW +: AW];
    assign ok = addr_live(32'(a), NREGS, ZERO_REG);
    // A same-cycle writeback both supplies the data and retires the pending bit
    assign hit = BYPASS != 0 && w_ok && wr_addr == a;
    assign rd_data[i*XLEN +: XLEN] = !ok ? '0 : hit ? wr_data : regs_q[a];
    assign rd_busy[i] = busy_raw[i] && !hit;
  end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed plus random checks of two configurations against a reference model
module tb_regfile_sb;
  logic clk = 0;
  logic reset, wr_en, iss_en, flush;
  logic [4:0] wr_addr, iss_rd;
  logic [31:0] wr_data;
  logic [4:0] ra [3];
  logic [9:0] rd_addr0;
  logic [14:0] rd_addr1;
  logic [63:0] rd_data0;
  logic [95:0] rd_data1;
  logic [1:0] rd_busy0;
  logic [2:0] rd_busy1;
  logic any0, any1;
  int n_checks = 0, n_errors = 0;
  logic [31:0] m_regs [2][64];
  logic m_pend [2][64];
  int cfg_n [2] = '{32, 24};
  int cfg_b [2] = '{1, 0};

  always #5 clk = ~clk;
  assign rd_addr0 = {ra[1], ra[0]};
  assign rd_addr1 = {ra[2], ra[1], ra[0]};

  regfile_sb dut0 (
    .clk(clk), .reset(reset), .rd_addr(rd_addr0), .rd_data(rd_data0), .rd_busy(rd_busy0),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en), .iss_rd(iss_rd),
    .flush(flush), .any_busy(any0)
  );
  regfile_sb #(.NREGS(24), .NREAD(3), .ZERO_REG(1), .BYPASS(0)) dut1 (
    .clk(clk), .reset(reset), .rd_addr(rd_addr1), .rd_data(rd_data1), .rd_busy(rd_busy1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en), .iss_rd(iss_rd),
    .flush(flush), .any_busy(any1)
  );

  function automatic bit live(int d, int a);
    return a < cfg_n[d] && a != 0;
  endfunction
  function automatic logic [31:0] exp_data(int d, int a);
    if (!live(d, a)) return 0;
    if (cfg_b[d] != 0 && wr_en && int'(wr_addr) == a) return wr_data;
    return m_regs[d][a];
  endfunction
  function automatic logic exp_busy(int d, int a);
    if (!live(d, a)) return 0;
    return m_pend[d][a] && !(cfg_b[d] != 0 && wr_en && int'(wr_addr) == a);
  endfunction
  function automatic logic exp_any(int d);
    for (int r = 0; r < cfg_n[d]; r++) if (m_pend[d][r]) return 1;
    return 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic settle();
    #4;
    for (int p = 0; p < 2; p++) begin
      check("d0_data", rd_data0[p*32 +: 32], exp_data(0, int'(ra[p])));
      check("d0_busy", 32'(rd_busy0[p]), 32'(exp_busy(0, int'(ra[p]))));
    end
    for (int p = 0; p < 3; p++) begin
      check("d1_data", rd_data1[p*32 +: 32], exp_data(1, int'(ra[p])));
      check("d1_busy", 32'(rd_busy1[p]), 32'(exp_busy(1, int'(ra[p]))));
    end
    check("d0_any", 32'(any0), 32'(exp_any(0)));
    check("d1_any", 32'(any1), 32'(exp_any(1)));
  endtask

  task automatic tick();
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        for (int r = 0; r < 64; r++) begin
          m_regs[d][r] = 0;
          m_pend[d][r] = 0;
        end
      end else begin
        if (wr_en && live(d, int'(wr_addr))) begin
          m_regs[d][wr_addr] = wr_data;
          m_pend[d][wr_addr] = 0;
        end
        if (flush) for (int r = 0; r < 64; r++) m_pend[d][r] = 0;
        if (iss_en && live(d, int'(iss_rd))) m_pend[d][iss_rd] = 1;
      end
    end
    #1;
  endtask

  task automatic idle();
    reset = 0; wr_en = 0; iss_en = 0; flush = 0;
  endtask

  task automatic wr(input int a, input logic [31:0] v);
    wr_en = 1; wr_addr = 5'(a); wr_data = v;
  endtask

  task automatic iss(input int a);
    iss_en = 1; iss_rd = 5'(a);
  endtask

  initial begin
    idle(); reset = 1; wr_addr = 0; wr_data = 0; iss_rd = 0;
    ra[0] = 0; ra[1] = 0; ra[2] = 0;
    tick();
    idle(); wr(5, 32'hDEAD); tick();
    idle(); iss(5); tick();
    idle(); ra[0] = 5; settle(); tick();
    reset = 1; tick();
    idle(); settle();
    check("rst_data", rd_data0[31:0], 0);
    check("rst_busy", 32'(rd_busy0[0]), 0);
    check("rst_any", 32'(any0), 0);
    tick();
    wr(10, 15); ra[1] = 10; settle();
    check("byp1_data", rd_data0[63:32], 15);
    check("byp0_old", rd_data1[63:32], 0);
    tick();
    idle(); settle();
    check("byp0_new", rd_data1[63:32], 15);
    iss(21); tick();
    idle(); ra[0] = 21; settle();
    check("sb_busy", 32'(rd_busy0[0]), 1);
    wr(21, 4); settle();
    check("sb_wb_busy", 32'(rd_busy0[0]), 0);
    check("sb_wb_data", rd_data0[31:0], 4);
    tick();
    idle(); settle();
    check("sb_d1_busy", 32'(rd_busy1[0]), 0);
    check("sb_d1_data", rd_data1[31:0], 4);
    iss(7); wr(7, 32'h55); tick();
    idle(); ra[0] = 7; settle();
    check("r7_busy", 32'(rd_busy0[0]), 1);
    check("r7_data", rd_data0[31:0], 32'h55);
    flush = 1; iss(9); tick();
    idle(); ra[1] = 9; settle();
    check("fl_r7", 32'(rd_busy0[0]), 0);
    check("fl_r9", 32'(rd_busy0[1]), 1);
    check("fl_any", 32'(any0), 1);
    flush = 1; tick();
    idle(); wr(0, 32'hFFFF); iss(0); tick();
    idle(); ra[0] = 0; settle();
    check("z_data", rd_data0[31:0], 0);
    check("z_busy", 32'(rd_busy0[0]), 0);
    check("z_any", 32'(any0), 0);
    reset = 1; wr(3, 32'h33); iss(3); tick();
    idle(); ra[0] = 3; settle();
    check("rp_data", rd_data0[31:0], 0);
    check("rp_busy", 32'(rd_busy0[0]), 0);
    wr(30, 32'h77); iss(30); tick();
    idle(); ra[2] = 30; settle();
    check("oor_data", rd_data1[95:64], 0);
    check("oor_busy", 32'(rd_busy1[2]), 0);
    check("oor_any", 32'(any1), 0);
    for (int c = 0; c < 2000; c++) begin
      reset = ($urandom_range(0, 99) == 0);
      flush = ($urandom_range(0, 19) == 0);
      wr_en = $urandom_range(0, 1) == 1;
      iss_en = $urandom_range(0, 1) == 1;
      wr_addr = 5'($urandom_range(0, 31));
      iss_rd = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
      wr_data = $urandom;
      for (int p = 0; p < 3; p++)
        ra[p] = ($urandom_range(0, 2) == 0) ? wr_addr : 5'($urandom_range(0, 31));
      settle();
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
